// File: rtl/ram_rr_arbiter_if.sv
// Avalon-MM master-side bundle for one requester of the shared RAM.
// master: drives the command fields; slave: returns waitrequest and read data.
interface ram_rr_arbiter_if #(
   parameter int AW = 12
) ();
   logic [AW-1:0] address;
   logic [3:0]    byteenable;
   logic          read;
   logic          write;
   logic [31:0]   writedata;
   logic          waitrequest;
   logic [31:0]   readdata;
   logic          readdatavalid;

   modport master (
      output address, byteenable, read, write, writedata,
      input  waitrequest, readdata, readdatavalid
   );

   modport slave (
      input  address, byteenable, read, write, writedata,
      output waitrequest, readdata, readdatavalid
   );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Two-master arbiter in front of a single-port RAM with one-cycle read latency.
// Ports: clk, reset_n (async low); m0/m1 Avalon slave bundles;
//        ram_*_o command to RAM, ram_readdata_i from RAM; oor_pulse_o per master.
module ram_rr_arbiter #(
   parameter int DEPTH      = 2560,
   parameter int AW         = 12,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   ram_rr_arbiter_if.slave      m0,
   ram_rr_arbiter_if.slave      m1,
   output logic [AW-1:0]        ram_address_o,
   output logic [3:0]           ram_byteenable_o,
   output logic                 ram_chipselect_o,
   output logic                 ram_write_o,
   output logic [31:0]          ram_writedata_o,
   input  logic [31:0]          ram_readdata_i,
   output logic [1:0]           oor_pulse_o
);

   localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

   logic          req0, req1;
   logic          gnt0, gnt1, any_gnt;
   logic          sel_wr, in_rng;
   logic [AW-1:0] sel_addr;
   logic [3:0]    sel_be;
   logic [31:0]   sel_wd;

   // last_q = 1 means m1 was granted last
   logic          last_q;
   logic [1:0]    rd_pend_q;
   logic [1:0]    oor_q;

   assign req0 = m0.read | m0.write;
   assign req1 = m1.read | m1.write;

   // m0 wins a conflict under fixed priority or when m1 went last
   assign gnt0    = reset_n & req0 & (~req1 | FIXED_PRIO | last_q);
   assign gnt1    = reset_n & req1 & ~gnt0;
   assign any_gnt = gnt0 | gnt1;

   always_comb begin
      sel_addr = '0;
      sel_be   = '0;
      sel_wd   = '0;
      sel_wr   = 1'b0;
      if (gnt1) begin
         sel_addr = m1.address;
         sel_be   = m1.byteenable;
         sel_wd   = m1.writedata;
         sel_wr   = m1.write;
      end else if (gnt0) begin
         sel_addr = m0.address;
         sel_be   = m0.byteenable;
         sel_wd   = m0.writedata;
         sel_wr   = m0.write;
      end
   end

   assign in_rng = ({1'b0, sel_addr} < LIM);

   assign ram_address_o    = sel_addr;
   assign ram_byteenable_o = sel_be;
   assign ram_writedata_o  = sel_wd;
   assign ram_chipselect_o = any_gnt & in_rng;
   assign ram_write_o      = any_gnt & sel_wr & in_rng;

   assign m0.waitrequest = req0 & ~gnt0;
   assign m1.waitrequest = req1 & ~gnt1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q    <= 1'b1;
         rd_pend_q <= '0;
         oor_q     <= '0;
      end else begin
         if (any_gnt) last_q <= gnt1;
         // write wins when read and write are both raised
         rd_pend_q <= {gnt1 & ~m1.write, gnt0 & ~m0.write};
         oor_q     <= {gnt1 & ~in_rng, gnt0 & ~in_rng};
      end
   end

   // out-of-range reads never selected the RAM, so return zero instead
   assign m0.readdatavalid = rd_pend_q[0];
   assign m1.readdatavalid = rd_pend_q[1];
   assign m0.readdata = (rd_pend_q[0] & ~oor_q[0]) ? ram_readdata_i : '0;
   assign m1.readdata = (rd_pend_q[1] & ~oor_q[1]) ? ram_readdata_i : '0;
   assign oor_pulse_o = oor_q;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter: round-robin and fixed-priority instances,
// each with its own behavioural one-cycle-latency RAM.
module tb_ram_rr_arbiter;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   ram_rr_arbiter_if #(.AW(12)) m0 ();
   ram_rr_arbiter_if #(.AW(12)) m1 ();
   ram_rr_arbiter_if #(.AW(12)) f0 ();
   ram_rr_arbiter_if #(.AW(12)) f1 ();

   logic [11:0] ra_addr, rb_addr;
   logic [3:0]  ra_be, rb_be;
   logic        ra_cs, ra_we, rb_cs, rb_we;
   logic [31:0] ra_wd, rb_wd;
   logic [31:0] ra_rd = 32'hFFFF_FFFF;
   logic [31:0] rb_rd = 32'hFFFF_FFFF;
   logic [1:0]  ra_oor, rb_oor;
   logic [31:0] mem_a [4096];
   logic [31:0] mem_b [4096];

   always #5 clk = ~clk;

   ram_rr_arbiter #(.DEPTH(2560), .AW(12), .FIXED_PRIO(1'b0)) u_rr (
      .clk              (clk),
      .reset_n          (reset_n),
      .m0               (m0),
      .m1               (m1),
      .ram_address_o    (ra_addr),
      .ram_byteenable_o (ra_be),
      .ram_chipselect_o (ra_cs),
      .ram_write_o      (ra_we),
      .ram_writedata_o  (ra_wd),
      .ram_readdata_i   (ra_rd),
      .oor_pulse_o      (ra_oor)
   );

   ram_rr_arbiter #(.DEPTH(2560), .AW(12), .FIXED_PRIO(1'b1)) u_fp (
      .clk              (clk),
      .reset_n          (reset_n),
      .m0               (f0),
      .m1               (f1),
      .ram_address_o    (rb_addr),
      .ram_byteenable_o (rb_be),
      .ram_chipselect_o (rb_cs),
      .ram_write_o      (rb_we),
      .ram_writedata_o  (rb_wd),
      .ram_readdata_i   (rb_rd),
      .oor_pulse_o      (rb_oor)
   );

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem_a[i] = 32'hA500_0000 | i;
         mem_b[i] = 32'hA500_0000 | i;
      end
   end

   always @(posedge clk) begin
      if (ra_cs) begin
         if (ra_we) begin
            for (int b = 0; b < 4; b++)
               if (ra_be[b]) mem_a[ra_addr][8*b +: 8] <= ra_wd[8*b +: 8];
         end else begin
            ra_rd <= mem_a[ra_addr];
         end
      end
   end

   always @(posedge clk) begin
      if (rb_cs) begin
         if (rb_we) begin
            for (int b = 0; b < 4; b++)
               if (rb_be[b]) mem_b[rb_addr][8*b +: 8] <= rb_wd[8*b +: 8];
         end else begin
            rb_rd <= mem_b[rb_addr];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic set(input int m, input logic rd, input logic wr,
                      input logic [11:0] a, input logic [3:0] be,
                      input logic [31:0] wd);
      case (m)
         0: begin
            m0.read = rd; m0.write = wr; m0.address = a;
            m0.byteenable = be; m0.writedata = wd;
         end
         1: begin
            m1.read = rd; m1.write = wr; m1.address = a;
            m1.byteenable = be; m1.writedata = wd;
         end
         2: begin
            f0.read = rd; f0.write = wr; f0.address = a;
            f0.byteenable = be; f0.writedata = wd;
         end
         3: begin
            f1.read = rd; f1.write = wr; f1.address = a;
            f1.byteenable = be; f1.writedata = wd;
         end
         default: ;
      endcase
   endtask

   task automatic idle(input int m);
      set(m, 1'b0, 1'b0, 12'd0, 4'h0, 32'h0);
   endtask

   task automatic next;
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int m = 0; m < 4; m++) idle(m);

      // reset: grants masked, registered outputs low
      set(0, 1'b1, 1'b0, 12'd5, 4'hF, 32'h0);
      #2;
      check("rst_wait0", m0.waitrequest, 1);
      check("rst_cs", ra_cs, 0);
      check("rst_rdv0", m0.readdatavalid, 0);
      check("rst_oor", ra_oor, 0);
      idle(0);
      next;
      next;
      reset_n = 1'b1;

      // single master write then read
      set(0, 1'b0, 1'b1, 12'd5, 4'hF, 32'hDEADBEEF);
      @(negedge clk);
      check("t1_wait0", m0.waitrequest, 0);
      check("t1_cs", ra_cs, 1);
      check("t1_we", ra_we, 1);
      next;
      set(0, 1'b1, 1'b0, 12'd5, 4'hF, 32'h0);
      @(negedge clk);
      check("t1_rwait0", m0.waitrequest, 0);
      check("t1_rdv_early", m0.readdatavalid, 0);
      next;
      idle(0);
      @(negedge clk);
      check("t1_rdv", m0.readdatavalid, 1);
      check("t1_data", m0.readdata, 32'hDEADBEEF);
      next;
      @(negedge clk);
      check("t1_rdv_late", m0.readdatavalid, 0);

      // byte lanes
      set(0, 1'b0, 1'b1, 12'd7, 4'hF, 32'h11223344);
      next;
      set(0, 1'b0, 1'b1, 12'd7, 4'h8, 32'hAA000000);
      next;
      set(0, 1'b1, 1'b0, 12'd7, 4'hF, 32'h0);
      next;
      idle(0);
      @(negedge clk);
      check("t2_rdv", m0.readdatavalid, 1);
      check("t2_data", m0.readdata, 32'hAA223344);
      next;

      // round-robin conflict; m0 went last so m1 wins first
      set(0, 1'b1, 1'b0, 12'd1, 4'hF, 32'h0);
      set(1, 1'b1, 1'b0, 12'd2, 4'hF, 32'h0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("rr_wait0", m0.waitrequest, (k % 2 == 0));
         check("rr_wait1", m1.waitrequest, (k % 2 == 1));
         if (k > 0) begin
            check("rr_rdv0", m0.readdatavalid, (k % 2 == 0));
            check("rr_rdv1", m1.readdatavalid, (k % 2 == 1));
            if (k % 2 == 1) check("rr_d1", m1.readdata, 32'hA5000002);
            else            check("rr_d0", m0.readdata, 32'hA5000001);
         end
         next;
      end
      idle(0);
      idle(1);
      @(negedge clk);
      check("rr_tail_rdv0", m0.readdatavalid, 1);
      check("rr_tail_d0", m0.readdata, 32'hA5000001);
      check("rr_tail_rdv1", m1.readdatavalid, 0);
      next;

      // fixed priority
      set(2, 1'b1, 1'b0, 12'd1, 4'hF, 32'h0);
      set(3, 1'b1, 1'b0, 12'd2, 4'hF, 32'h0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("fp_wait0", f0.waitrequest, 0);
         check("fp_wait1", f1.waitrequest, 1);
         if (k > 0) check("fp_d0", f0.readdata, 32'hA5000001);
         next;
      end
      idle(2);
      @(negedge clk);
      check("fp_wait1_free", f1.waitrequest, 0);
      check("fp_rdv0", f0.readdatavalid, 1);
      next;
      idle(3);
      @(negedge clk);
      check("fp_rdv1", f1.readdatavalid, 1);
      check("fp_d1", f1.readdata, 32'hA5000002);
      check("fp_rdv0_off", f0.readdatavalid, 0);
      next;

      // out-of-range from m1
      set(1, 1'b0, 1'b1, 12'd2560, 4'hF, 32'h12345678);
      @(negedge clk);
      check("oor_wait1", m1.waitrequest, 0);
      check("oor_cs_w", ra_cs, 0);
      check("oor_we", ra_we, 0);
      next;
      set(1, 1'b1, 1'b0, 12'd2560, 4'hF, 32'h0);
      @(negedge clk);
      check("oor_p_w", ra_oor, 2'b10);
      check("oor_cs_r1", ra_cs, 0);
      next;
      set(1, 1'b1, 1'b0, 12'd4095, 4'hF, 32'h0);
      @(negedge clk);
      check("oor_cs_r2", ra_cs, 0);
      check("oor_rdv_a", m1.readdatavalid, 1);
      check("oor_d_a", m1.readdata, 32'h0);
      check("oor_p_a", ra_oor, 2'b10);
      next;
      idle(1);
      @(negedge clk);
      check("oor_rdv_b", m1.readdatavalid, 1);
      check("oor_d_b", m1.readdata, 32'h0);
      check("oor_p_b", ra_oor, 2'b10);
      next;
      set(0, 1'b1, 1'b0, 12'd0, 4'hF, 32'h0);
      @(negedge clk);
      check("oor_p_idle", ra_oor, 2'b00);
      next;
      idle(0);
      @(negedge clk);
      check("oor_addr0", m0.readdata, 32'hA5000000);
      next;

      // reset between read acceptance and its return
      set(0, 1'b1, 1'b0, 12'd3, 4'hF, 32'h0);
      next;
      reset_n = 1'b0;
      #1;
      check("mr_rdv0", m0.readdatavalid, 0);
      check("mr_d0", m0.readdata, 32'h0);
      idle(0);
      next;
      reset_n = 1'b1;
      @(negedge clk);
      check("mr_rdv0_after", m0.readdatavalid, 0);
      next;
      set(0, 1'b1, 1'b0, 12'd1, 4'hF, 32'h0);
      set(1, 1'b1, 1'b0, 12'd2, 4'hF, 32'h0);
      @(negedge clk);
      check("mr_wait0", m0.waitrequest, 0);
      check("mr_wait1", m1.waitrequest, 1);
      next;
      @(negedge clk);
      check("mr_rdv0", m0.readdatavalid, 1);
      check("mr_d0b", m0.readdata, 32'hA5000001);
      check("mr_wait1b", m1.waitrequest, 0);
      next;
      idle(0);
      idle(1);
      @(negedge clk);
      check("mr_rdv1", m1.readdatavalid, 1);
      check("mr_d1", m1.readdata, 32'hA5000002);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
